// File: rtl/riscv_trace_monitor_if.sv
// Trace stream between the commit monitor (master) and a trace consumer (slave).
// The head entry is presented show-ahead and popped with a valid/ready handshake.
interface riscv_trace_monitor_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) ();
    logic                   tr_valid;
    logic                   tr_ready;
    logic [1:0]             tr_kind;
    logic [4:0]             tr_rd;
    logic [XLEN-1:0]        tr_result;
    logic [XLEN-1:0]        tr_addr;
    logic [XLEN-1:0]        tr_data;
    logic [CNT_W-1:0]       tr_cycle;
    logic [$clog2(DEPTH):0] tr_count;

    modport master (
        output tr_valid, tr_kind, tr_rd, tr_result, tr_addr, tr_data, tr_cycle, tr_count,
        input  tr_ready
    );

    modport slave (
        input  tr_valid, tr_kind, tr_rd, tr_result, tr_addr, tr_data, tr_cycle, tr_count,
        output tr_ready
    );
endinterface

// File: rtl/riscv_trace_monitor.sv
// Commit-trace and performance monitor for the pipelined RV32I core: logs one
// timestamped entry per writeback/store cycle into a FIFO and keeps hazard counters.
module riscv_trace_monitor #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    parameter int OVERWRITE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 wb_regwrite,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_result,
    input  logic                 mem_we,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [XLEN-1:0]      mem_data,
    input  logic                 stall_f,
    input  logic                 flush_d,
    input  logic                 flush_e,
    riscv_trace_monitor_if.master trace,
    output logic [CNT_W-1:0]     cyc_cnt,
    output logic [CNT_W-1:0]     wb_cnt,
    output logic [CNT_W-1:0]     st_cnt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     drop_cnt
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic            LP_OW      = (OVERWRITE != 0);
    localparam logic [AW:0]     LP_PTR_ONE = 1;
    localparam logic [CNT_W-1:0] LP_ONE    = 1;

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_wb;
    logic [CNT_W-1:0] r_st;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;
    logic [CNT_W-1:0] r_drop;

    logic [1:0]       r_kind   [DEPTH];
    logic [4:0]       r_rd     [DEPTH];
    logic [XLEN-1:0]  r_result [DEPTH];
    logic [XLEN-1:0]  r_addr   [DEPTH];
    logic [XLEN-1:0]  r_data   [DEPTH];
    logic [CNT_W-1:0] r_cycle  [DEPTH];

    logic          w_wb_ev;
    logic          w_st_ev;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_write;
    logic          w_drop;
    logic          w_rptr_adv;
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;

    // Writes to x0 are architecturally invisible, so they are not trace events.
    assign w_wb_ev = wb_regwrite & (wb_rd != 5'd0);
    assign w_st_ev = mem_we;

    assign w_widx  = r_wptr[AW-1:0];
    assign w_ridx  = r_rptr[AW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);

    assign w_push  = en_i & ~clr_i & (w_wb_ev | w_st_ev);
    assign w_pop   = ~clr_i & ~w_empty & trace.tr_ready;

    // A same-cycle pop frees a slot, so only a full FIFO without a pop drops.
    assign w_drop     = w_push & w_full & ~w_pop;
    assign w_write    = w_push & (~w_full | w_pop | LP_OW);
    assign w_rptr_adv = w_pop | (w_drop & LP_OW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= '0;
        end else if (clr_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= '0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + LP_PTR_ONE;
            end
            if (w_rptr_adv) begin
                r_rptr <= r_rptr + LP_PTR_ONE;
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + LP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc   <= '0;
            r_wb    <= '0;
            r_st    <= '0;
            r_stall <= '0;
            r_flush <= '0;
        end else if (clr_i) begin
            r_cyc   <= '0;
            r_wb    <= '0;
            r_st    <= '0;
            r_stall <= '0;
            r_flush <= '0;
        end else if (en_i) begin
            r_cyc <= r_cyc + LP_ONE;
            if (w_wb_ev) begin
                r_wb <= r_wb + LP_ONE;
            end
            if (w_st_ev) begin
                r_st <= r_st + LP_ONE;
            end
            if (stall_f) begin
                r_stall <= r_stall + LP_ONE;
            end
            if (flush_d || flush_e) begin
                r_flush <= r_flush + LP_ONE;
            end
        end
    end

    // Entry storage is not reset; the pointers alone decide what is presented.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_kind[w_widx]   <= {w_st_ev, w_wb_ev};
            r_rd[w_widx]     <= w_wb_ev ? wb_rd     : 5'd0;
            r_result[w_widx] <= w_wb_ev ? wb_result : '0;
            r_addr[w_widx]   <= w_st_ev ? mem_addr  : '0;
            r_data[w_widx]   <= w_st_ev ? mem_data  : '0;
            r_cycle[w_widx]  <= r_cyc;
        end
    end

    assign trace.tr_valid  = ~w_empty;
    assign trace.tr_kind   = w_empty ? 2'b00 : r_kind[w_ridx];
    assign trace.tr_rd     = w_empty ? 5'd0  : r_rd[w_ridx];
    assign trace.tr_result = w_empty ? '0    : r_result[w_ridx];
    assign trace.tr_addr   = w_empty ? '0    : r_addr[w_ridx];
    assign trace.tr_data   = w_empty ? '0    : r_data[w_ridx];
    assign trace.tr_cycle  = w_empty ? '0    : r_cycle[w_ridx];
    assign trace.tr_count  = r_wptr - r_rptr;

    assign cyc_cnt   = r_cyc;
    assign wb_cnt    = r_wb;
    assign st_cnt    = r_st;
    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;
    assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_riscv_trace_monitor.sv
// Bench for riscv_trace_monitor: drop-newest and evict-oldest instances (DEPTH=4,
// 8-bit counters) share stimulus and are compared every cycle against a queue model.
module tb_riscv_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    typedef struct packed {
        logic [1:0]       kind;
        logic [4:0]       rd;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [CNT_W-1:0] cyc;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b1;
    logic            clr = 1'b0;
    logic            wbRegwrite = 1'b0;
    logic [4:0]      wbRd = '0;
    logic [XLEN-1:0] wbResult = '0;
    logic            memWe = 1'b0;
    logic [XLEN-1:0] memAddr = '0;
    logic [XLEN-1:0] memData = '0;
    logic            stallF = 1'b0;
    logic            flushD = 1'b0;
    logic            flushE = 1'b0;
    logic            trReady = 1'b0;
    logic            obsEnable = 1'b0;

    logic [CNT_W-1:0] cyc0, wb0, st0, stall0, flush0, drop0;
    logic [CNT_W-1:0] cyc1, wb1, st1, stall1, flush1, drop1;

    int checks = 0;
    int errors = 0;

    entry_t mMem [2][DEPTH];
    int     mCount [2];
    int     mDrop [2];
    int     mCyc, mWb, mSt, mStall, mFlush;
    entry_t obsQ [$];

    riscv_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) trIf0 ();
    riscv_trace_monitor_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) trIf1 ();

    assign trIf0.tr_ready = trReady;
    assign trIf1.tr_ready = trReady;

    riscv_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .OVERWRITE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr),
        .wb_regwrite(wbRegwrite), .wb_rd(wbRd), .wb_result(wbResult),
        .mem_we(memWe), .mem_addr(memAddr), .mem_data(memData),
        .stall_f(stallF), .flush_d(flushD), .flush_e(flushE),
        .trace(trIf0),
        .cyc_cnt(cyc0), .wb_cnt(wb0), .st_cnt(st0),
        .stall_cnt(stall0), .flush_cnt(flush0), .drop_cnt(drop0)
    );

    riscv_trace_monitor #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W), .OVERWRITE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr),
        .wb_regwrite(wbRegwrite), .wb_rd(wbRd), .wb_result(wbResult),
        .mem_we(memWe), .mem_addr(memAddr), .mem_data(memData),
        .stall_f(stallF), .flush_d(flushD), .flush_e(flushE),
        .trace(trIf1),
        .cyc_cnt(cyc1), .wb_cnt(wb1), .st_cnt(st1),
        .stall_cnt(stall1), .flush_cnt(flush1), .drop_cnt(drop1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mCount[i] = 0;
            mDrop[i]  = 0;
        end
        mCyc = 0; mWb = 0; mSt = 0; mStall = 0; mFlush = 0;
    endtask

    // Reference: each instance holds an ordered list, head at index 0; instance 1 evicts.
    always @(posedge clk or negedge rst_n) begin : model
        entry_t e;
        logic   wbEv, stEv, push, pop;
        if (!rst_n || clr) begin
            modelReset();
        end else begin
            wbEv = wbRegwrite && (wbRd != 5'd0);
            stEv = memWe;
            push = en && (wbEv || stEv);
            e = '0;
            e.kind = {stEv, wbEv};
            if (wbEv) begin
                e.rd = wbRd;
                e.result = wbResult;
            end
            if (stEv) begin
                e.addr = memAddr;
                e.data = memData;
            end
            e.cyc = CNT_W'(mCyc);
            for (int i = 0; i < 2; i++) begin
                pop = (mCount[i] > 0) && trReady;
                if (pop) begin
                    for (int k = 0; k < DEPTH - 1; k++) mMem[i][k] = mMem[i][k+1];
                    mCount[i]--;
                end
                if (push) begin
                    if (mCount[i] < DEPTH) begin
                        mMem[i][mCount[i]] = e;
                        mCount[i]++;
                    end else begin
                        if (mDrop[i] < CMAX) mDrop[i]++;
                        if (i == 1) begin
                            for (int k = 0; k < DEPTH - 1; k++) mMem[i][k] = mMem[i][k+1];
                            mMem[i][DEPTH-1] = e;
                        end
                    end
                end
            end
            if (en) begin
                mCyc = (mCyc + 1) % (CMAX + 1);
                if (wbEv) mWb = (mWb + 1) % (CMAX + 1);
                if (stEv) mSt = (mSt + 1) % (CMAX + 1);
                if (stallF) mStall = (mStall + 1) % (CMAX + 1);
                if (flushD || flushE) mFlush = (mFlush + 1) % (CMAX + 1);
            end
        end
    end

    task automatic compareInst(input int i, input logic v, input logic [1:0] k, input logic [4:0] rd,
                               input logic [XLEN-1:0] res, input logic [XLEN-1:0] addr,
                               input logic [XLEN-1:0] data, input logic [CNT_W-1:0] cyc,
                               input logic [2:0] cnt, input logic [CNT_W-1:0] cc,
                               input logic [CNT_W-1:0] wc, input logic [CNT_W-1:0] sc,
                               input logic [CNT_W-1:0] stc, input logic [CNT_W-1:0] fc,
                               input logic [CNT_W-1:0] dc);
        entry_t h;
        h = '0;
        if (mCount[i] > 0) h = mMem[i][0];
        checkOutput($sformatf("dut%0d tr_valid", i), 64'(v), 64'(mCount[i] > 0));
        checkOutput($sformatf("dut%0d tr_kind", i), 64'(k), 64'(h.kind));
        checkOutput($sformatf("dut%0d tr_rd", i), 64'(rd), 64'(h.rd));
        checkOutput($sformatf("dut%0d tr_result", i), 64'(res), 64'(h.result));
        checkOutput($sformatf("dut%0d tr_addr", i), 64'(addr), 64'(h.addr));
        checkOutput($sformatf("dut%0d tr_data", i), 64'(data), 64'(h.data));
        checkOutput($sformatf("dut%0d tr_cycle", i), 64'(cyc), 64'(h.cyc));
        checkOutput($sformatf("dut%0d tr_count", i), 64'(cnt), 64'(mCount[i]));
        checkOutput($sformatf("dut%0d cyc_cnt", i), 64'(cc), 64'(mCyc));
        checkOutput($sformatf("dut%0d wb_cnt", i), 64'(wc), 64'(mWb));
        checkOutput($sformatf("dut%0d st_cnt", i), 64'(sc), 64'(mSt));
        checkOutput($sformatf("dut%0d stall_cnt", i), 64'(stc), 64'(mStall));
        checkOutput($sformatf("dut%0d flush_cnt", i), 64'(fc), 64'(mFlush));
        checkOutput($sformatf("dut%0d drop_cnt", i), 64'(dc), 64'(mDrop[i]));
    endtask

    // Outputs are sampled on the falling edge, half a cycle after the state update.
    always @(negedge clk) begin : compare
        compareInst(0, trIf0.tr_valid, trIf0.tr_kind, trIf0.tr_rd, trIf0.tr_result, trIf0.tr_addr,
                    trIf0.tr_data, trIf0.tr_cycle, trIf0.tr_count, cyc0, wb0, st0, stall0, flush0, drop0);
        compareInst(1, trIf1.tr_valid, trIf1.tr_kind, trIf1.tr_rd, trIf1.tr_result, trIf1.tr_addr,
                    trIf1.tr_data, trIf1.tr_cycle, trIf1.tr_count, cyc1, wb1, st1, stall1, flush1, drop1);
    end

    always @(negedge clk) begin : observe
        if (obsEnable && trIf0.tr_valid && trReady) begin
            obsQ.push_back({trIf0.tr_kind, trIf0.tr_rd, trIf0.tr_result, trIf0.tr_addr,
                            trIf0.tr_data, trIf0.tr_cycle});
        end
    end

    task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] rd, input logic [XLEN-1:0] res,
                                 input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
        wbRegwrite = kind[0];
        wbRd       = rd;
        wbResult   = res;
        memWe      = kind[1];
        memAddr    = addr;
        memData    = data;
        @(negedge clk);
        wbRegwrite = 1'b0; wbRd = '0; wbResult = '0;
        memWe = 1'b0; memAddr = '0; memData = '0;
    endtask

    task automatic idleCycles(input int n);
        wbRegwrite = 1'b0; wbRd = '0; wbResult = '0;
        memWe = 1'b0; memAddr = '0; memData = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clearPulse();
        clr = 1'b1;
        idleCycles(1);
        clr = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        logic [1:0]      expKind [6];
        logic [4:0]      expRd [6];
        logic [XLEN-1:0] expRes [6];
        logic [XLEN-1:0] expData [6];
        expKind = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        expRd   = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd7, 5'd9};
        expRes  = '{32'd5, 32'd10, 32'd15, 32'd0, 32'd15, 32'd9};
        expData = '{32'd0, 32'd0, 32'd0, 32'd15, 32'd0, 32'd0};

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset tr_valid", 64'(trIf0.tr_valid), 64'd0);
        checkOutput("reset tr_count", 64'(trIf0.tr_count), 64'd0);
        checkOutput("reset cyc_cnt", 64'(cyc0), 64'd0);
        rst_n = 1'b1;
        idleCycles(1);
        checkOutput("first cyc_cnt", 64'(cyc0), 64'd1);

        $display("[TB] standard program");
        trReady = 1'b1;
        obsEnable = 1'b1;
        applyStimulus(2'b01, 5'd1, 32'd5, 32'd0, 32'd0);  idleCycles(1);
        applyStimulus(2'b01, 5'd2, 32'd10, 32'd0, 32'd0); idleCycles(1);
        applyStimulus(2'b01, 5'd3, 32'd15, 32'd0, 32'd0); idleCycles(1);
        applyStimulus(2'b10, 5'd0, 32'd0, 32'd0, 32'd15); idleCycles(1);
        applyStimulus(2'b01, 5'd7, 32'd15, 32'd0, 32'd0); idleCycles(1);
        applyStimulus(2'b01, 5'd9, 32'd9, 32'd0, 32'd0);  idleCycles(2);
        obsEnable = 1'b0;
        checkOutput("std entry count", 64'(obsQ.size()), 64'd6);
        for (int i = 0; i < obsQ.size() && i < 6; i++) begin
            checkOutput($sformatf("std[%0d] kind", i), 64'(obsQ[i].kind), 64'(expKind[i]));
            checkOutput($sformatf("std[%0d] rd", i), 64'(obsQ[i].rd), 64'(expRd[i]));
            checkOutput($sformatf("std[%0d] result", i), 64'(obsQ[i].result), 64'(expRes[i]));
            checkOutput($sformatf("std[%0d] addr", i), 64'(obsQ[i].addr), 64'd0);
            checkOutput($sformatf("std[%0d] data", i), 64'(obsQ[i].data), 64'(expData[i]));
            if (i > 0) checkOutput($sformatf("std[%0d] stamp increasing", i),
                                   64'(obsQ[i].cyc > obsQ[i-1].cyc), 64'd1);
        end
        checkOutput("std wb_cnt", 64'(wb0), 64'd5);
        checkOutput("std st_cnt", 64'(st0), 64'd1);

        $display("[TB] x0 write and combined event");
        clearPulse();
        trReady = 1'b0;
        applyStimulus(2'b01, 5'd0, 32'd77, 32'd0, 32'd0);
        checkOutput("x0 tr_count", 64'(trIf0.tr_count), 64'd0);
        checkOutput("x0 wb_cnt", 64'(wb0), 64'd0);
        applyStimulus(2'b11, 5'd4, 32'd44, 32'd100, 32'd200);
        checkOutput("both tr_kind", 64'(trIf0.tr_kind), 64'd3);
        checkOutput("both tr_rd", 64'(trIf0.tr_rd), 64'd4);
        checkOutput("both tr_addr", 64'(trIf0.tr_addr), 64'd100);

        $display("[TB] full FIFO policies");
        clearPulse();
        for (int i = 1; i <= 6; i++) applyStimulus(2'b01, 5'(i), 32'(i * 11), 32'd0, 32'd0);
        checkOutput("drop-new tr_count", 64'(trIf0.tr_count), 64'd4);
        checkOutput("drop-new head rd", 64'(trIf0.tr_rd), 64'd1);
        checkOutput("drop-new drop_cnt", 64'(drop0), 64'd2);
        checkOutput("evict tr_count", 64'(trIf1.tr_count), 64'd4);
        checkOutput("evict head rd", 64'(trIf1.tr_rd), 64'd3);
        checkOutput("evict drop_cnt", 64'(drop1), 64'd2);
        trReady = 1'b1;
        applyStimulus(2'b01, 5'd7, 32'd77, 32'd0, 32'd0);
        trReady = 1'b0;
        checkOutput("full push+pop tr_count", 64'(trIf0.tr_count), 64'd4);
        checkOutput("full push+pop drop_cnt", 64'(drop0), 64'd2);
        checkOutput("full push+pop head rd", 64'(trIf0.tr_rd), 64'd2);
        checkOutput("evict push+pop head rd", 64'(trIf1.tr_rd), 64'd4);

        $display("[TB] hazard counters and enable");
        clearPulse();
        stallF = 1'b1; idleCycles(3); stallF = 1'b0;
        flushD = 1'b1; flushE = 1'b1; idleCycles(1); flushD = 1'b0; flushE = 1'b0;
        en = 1'b0; idleCycles(2); en = 1'b1;
        idleCycles(2);
        checkOutput("hazard stall_cnt", 64'(stall0), 64'd3);
        checkOutput("hazard flush_cnt", 64'(flush0), 64'd1);
        checkOutput("hazard cyc_cnt", 64'(cyc0), 64'd6);

        $display("[TB] clear and reset mid-stream");
        clearPulse();
        for (int i = 1; i <= 3; i++) applyStimulus(2'b01, 5'(i + 10), 32'(i), 32'd0, 32'd0);
        clr = 1'b1;
        applyStimulus(2'b11, 5'd5, 32'd55, 32'd4, 32'd66);
        clr = 1'b0;
        checkOutput("clr tr_count", 64'(trIf0.tr_count), 64'd0);
        checkOutput("clr tr_valid", 64'(trIf0.tr_valid), 64'd0);
        checkOutput("clr counters", 64'({cyc0, wb0, st0, stall0, flush0, drop0}), 64'd0);
        applyStimulus(2'b01, 5'd6, 32'd66, 32'd0, 32'd0);
        applyStimulus(2'b10, 5'd0, 32'd0, 32'd8, 32'd88);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst tr_valid", 64'(trIf0.tr_valid), 64'd0);
        checkOutput("rst tr_count", 64'(trIf0.tr_count), 64'd0);
        checkOutput("rst tr_fields", 64'(trIf0.tr_rd) | 64'(trIf0.tr_result) | 64'(trIf0.tr_cycle), 64'd0);
        checkOutput("rst counters", 64'({cyc0, wb0, st0, stall0, flush0, drop0}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] drop saturation and counter wrap");
        trReady = 1'b0;
        for (int i = 0; i < 300; i++) applyStimulus(2'b10, 5'd0, 32'd0, 32'(i), 32'(i * 3));
        checkOutput("sat drop_cnt dut0", 64'(drop0), 64'd255);
        checkOutput("sat drop_cnt dut1", 64'(drop1), 64'd255);

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            en         = ($urandom % 10) != 0;
            clr        = ($urandom % 80) == 0;
            wbRegwrite = $urandom % 2;
            wbRd       = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            wbResult   = $urandom;
            memWe      = ($urandom % 3) == 0;
            memAddr    = $urandom;
            memData    = $urandom;
            stallF     = ($urandom % 4) == 0;
            flushD     = ($urandom % 6) == 0;
            flushE     = ($urandom % 6) == 0;
            trReady    = $urandom % 2;
            @(negedge clk);
        end
        en = 1'b1; clr = 1'b0; stallF = 1'b0; flushD = 1'b0; flushE = 1'b0;
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_trace_monitor.md
# riscv_trace_monitor

Synthesizable, parametrised commit-trace and performance monitor for the pipelined RV32I core. It samples the writeback and data-memory-write ports every cycle and stores one timestamped trace entry per event cycle in an internal FIFO. It also keeps hazard/performance counters, so on-chip debug or a bench can read execution history without hierarchical probing. It sits beside the core top level and is fed only from existing W-stage, M-stage and hazard-unit signals.

## Interface

- XLEN, 32, data/address width
- DEPTH, 16, trace FIFO entries; power of two, ≥2
- CNT_W, 32, width of cycle stamp and all counters
- OVERWRITE, 0, full policy: 0 = drop newest, 1 = evict oldest
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en_i  in  1  capture/count enable
- clr_i  in  1  synchronous clear of FIFO and counters
- wb_regwrite  in  1  RegWriteW
- wb_rd  in  5  RdW
- wb_result  in  XLEN  ResultW
- mem_we  in  1  data-memory write enable
- mem_addr  in  XLEN  data-memory address
- mem_data  in  XLEN  data-memory write data
- stall_f  in  1  StallF
- flush_d  in  1  FlushD
- flush_e  in  1  FlushE
- tr_valid  out  1  head entry available
- tr_ready  in  1  consumer pops head when tr_valid
- tr_kind  out  2  bit0 = register write, bit1 = store
- tr_rd  out  5  destination register (0 if bit0 clear)
- tr_result  out  XLEN  written register value
- tr_addr  out  XLEN  store address
- tr_data  out  XLEN  store data
- tr_cycle  out  CNT_W  cycle stamp of entry
- tr_count  out  $clog2(DEPTH)+1  entries held
- cyc_cnt, wb_cnt, st_cnt, stall_cnt, flush_cnt, drop_cnt  out  CNT_W each  counters

## Operation

- Event qualification: wb_ev = wb_regwrite & (wb_rd != 0); st_ev = mem_we. A cycle with wb_ev|st_ev and en_i=1 produces exactly one entry carrying both fields. Fields of an absent event are stored as 0.
- Entry stamp = cyc_cnt value before that edge's increment.
- Counters, updated only when en_i=1:
  - cyc_cnt +1 every cycle.
  - wb_cnt +1 per wb_ev.
  - st_cnt +1 per st_ev.
  - stall_cnt +1 per stall_f.
  - flush_cnt +1 per cycle with flush_d|flush_e; a simultaneous flush_d and flush_e counts once.
- Counter width: cyc_cnt, wb_cnt, st_cnt, stall_cnt and flush_cnt wrap modulo 2^CNT_W. drop_cnt saturates at all-ones.
- FIFO storage: circular buffer with read/write pointers of $clog2(DEPTH) bits plus a wrap bit. Head entry is show-ahead: tr_* are read combinationally from the register array at the read pointer.
- Pop: occurs when tr_valid & tr_ready, independent of en_i.
- Empty FIFO: tr_valid=0 and tr_* = 0. There is no bypass; a pushed entry first becomes visible the cycle after it is written.
- Full FIFO, push, no pop:
  - OVERWRITE=0: new entry is discarded, drop_cnt +1.
  - OVERWRITE=1: oldest entry is evicted (read pointer advances), new entry is written, drop_cnt +1, tr_count stays at DEPTH.
- Full FIFO, push and pop in the same cycle: both occur, no drop, tr_count unchanged.
- clr_i=1: at the next edge, pointers, tr_count and all counters go to 0. clr_i has priority over push, pop and count. Events in the clear cycle are lost and not counted.
- Reset (rst_n low, at any time including mid-stream): all outputs 0 immediately. tr_valid=0, tr_count=0, all counters 0. Array contents need not reset but are never presented while empty.

## Timing

- Event-to-visibility latency: 1 cycle (sampled at edge N, tr_valid high after edge N).
- Counter values after edge N include the events of the cycle ending at N.
- Handshake: the consumer may hold tr_ready high continuously for 1 pop per cycle. tr_* hold stable while tr_valid & !tr_ready, except under OVERWRITE=1 eviction, where the head advances without a pop.
- Throughput: 1 push and 1 pop per cycle sustained. No combinational path from tr_ready to any output other than through registers.
- Deassertion of rst_n is applied synchronously to clk by the top level. The block needs no internal synchronizer.

## Test plan

- Core runs the standard program (x1=5, x2=10, x3=x1+x2, sw x3→0, lw x7, addi x9=9), tr_ready=1 → entries in order: rd1/5, rd2/10, rd3/15, store addr 0 data 15, rd7/15, rd9/9. wb_cnt=5, st_cnt=1, tr_cycle strictly increasing.
- wb_regwrite=1 with wb_rd=0 plus mem_we=0 → no entry, wb_cnt unchanged. wb_rd=4 and mem_we=1 in the same cycle → one entry with tr_kind=11.
- OVERWRITE=0, DEPTH=4, tr_ready=0, 6 event cycles → tr_count=4, head is the first event, drop_cnt=2. OVERWRITE=1 with the same stimulus → head is the 3rd event, drop_cnt=2.
- Full FIFO with push and pop in the same cycle → tr_count stays 4, drop_cnt stays 0, head advances by one.
- stall_f high 3 cycles; flush_d and flush_e both high 1 cycle; en_i low 2 cycles mid-run → stall_cnt=3, flush_cnt=1, cyc_cnt lower than elapsed cycles by 2.
- clr_i pulse with 3 entries held and an event present, then rst_n low mid-stream → after clr: tr_count=0, all counters 0, event not logged. On rst_n low: tr_valid drops immediately, all outputs 0.
